// File: rtl/div_int32_pkg.sv
// Shared opcode and FSM state definitions for the integer divider.
package div_int32_pkg;

  localparam logic [1:0] DIV_UNSIGNED = 2'b00;
  localparam logic [1:0] DIV_SIGNED   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/div_int_step.sv
// One radix-2 non-restoring iteration on a WIDTH+1-bit partial remainder.
module div_int_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Wraps modulo 2^(WIDTH+1); the true result always lies in [-divisor, divisor).
  always_comb begin
    shifted  = {rem[WIDTH-1:0], bit_in};
    rem_next = rem[WIDTH] ? shifted + {1'b0, divisor} : shifted - {1'b0, divisor};
    q_bit    = ~rem_next[WIDTH];
  end

endmodule

// File: rtl/div_int32.sv
// Iterative radix-2 non-restoring divider, signed/unsigned, 35-cycle latency.
// DIV_INT_EARLY_OUT_EN: skip iteration when divisor is 0 or |dividend| < |divisor|.
module div_int32
  import div_int32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   dvd_q, dvs_q, acc_q;
  logic [WIDTH:0]     rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q, sign_r, zero_q;

  logic               is_signed;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag, q_out, r_mag, r_out;
  logic [WIDTH:0]     rem_fix, step_rem;
  logic               step_q;

  always_comb begin
    is_signed = (op_q == DIV_SIGNED);
    dvd_mag   = (is_signed && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    dvs_mag   = (is_signed && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    rem_fix   = rem_q[WIDTH] ? rem_q + {1'b0, dvs_q} : rem_q;
    r_mag     = rem_fix[WIDTH-1:0];
    q_out     = sign_q ? -acc_q : acc_q;
    r_out     = sign_r ? -r_mag : r_mag;
  end

  div_int_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .bit_in  (acc_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_q      <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            op_q    <= opcode;
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            busy    <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          // dvd_q keeps the raw dividend for the divide-by-zero remainder.
          dvs_q   <= dvs_mag;
          acc_q   <= dvd_mag;
          rem_q   <= '0;
          sign_q  <= is_signed & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          sign_r  <= is_signed & dvd_q[WIDTH-1];
          zero_q  <= (dvs_q == '0);
          cnt_q   <= CNT_W'(WIDTH - 1);
          state_q <= S_CALC;
`ifdef DIV_INT_EARLY_OUT_EN
          if (dvs_q == '0 || dvd_mag < dvs_mag) begin
            acc_q   <= '0;
            rem_q   <= {1'b0, dvd_mag};
            state_q <= S_FIX;
          end
`endif
        end
        S_CALC: begin
          rem_q <= step_rem;
          acc_q <= {acc_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          busy    <= 1'b0;
          valid   <= 1'b1;
          state_q <= S_IDLE;
          if (op_q != DIV_UNSIGNED && op_q != DIV_SIGNED) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end else if (zero_q) begin
            quotient    <= '1;
            remainder   <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_out;
            remainder   <= r_out;
            div_by_zero <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_int32.sv
// Scoreboard bench for div_int32: directed corner cases plus random signed/unsigned ops.
module tb_div_int32;
  import div_int32_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  opcode;
  logic [31:0] dividend, divisor;
  logic        busy, valid, div_by_zero;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        flag;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  div_int32 #(
    .WIDTH(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .opcode     (opcode),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int unsigned c);
    exp_t        e;
    logic [31:0] ma, mb;
    int unsigned lat;
    ma  = (op == DIV_SIGNED && a[31]) ? -a : a;
    mb  = (op == DIV_SIGNED && b[31]) ? -b : b;
    lat = 35;
`ifdef DIV_INT_EARLY_OUT_EN
    if (b == 0 || ma < mb) lat = 3;
`endif
    e.cyc  = c + lat;
    e.flag = 1'b0;
    if (op != DIV_UNSIGNED && op != DIV_SIGNED) begin
      e.q = 0;
      e.r = 0;
    end else if (b == 0) begin
      e.q    = 32'hFFFF_FFFF;
      e.r    = a;
      e.flag = 1'b1;
    end else if (op == DIV_UNSIGNED) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a;
      e.r = 0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 64'(valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("quotient", 64'(quotient), 64'(e.q));
        check_eq("remainder", 64'(remainder), 64'(e.r));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(e.flag));
        check_eq("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of d1.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) begin
      check_eq("idle_timeout", 64'(busy), 64'd0);
      return;
    end
    en       = 1'b1;
    opcode   = op;
    dividend = a;
    divisor  = b;
    sb.push_back(model(op, a, b, cyc));
    @(negedge clock);
    en       = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_valid"}, 64'(valid), 64'd0);
    check_eq({tag, "_q"}, 64'(quotient), 64'd0);
    check_eq({tag, "_r"}, 64'(remainder), 64'd0);
    check_eq({tag, "_flag"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    int          nbusy;
    int          i;
    logic [1:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; en = 1'b0; opcode = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Busy must span exactly d1..d34.
    do_op(DIV_UNSIGNED, 32'd100, 32'd7);
    nbusy = 0;
    i = 0;
    while (i < 100 && valid !== 1'b1) begin
      if (busy) nbusy++;
      @(negedge clock);
      i++;
    end
    check_eq("busy_cycles", 64'(nbusy), 64'd34);

    do_op(DIV_SIGNED, -32'sd7, 32'd2);
    do_op(DIV_SIGNED, 32'd7, -32'sd2);
    do_op(DIV_UNSIGNED, 32'd5, 32'd0);
    do_op(DIV_SIGNED, 32'd5, 32'd0);
    do_op(DIV_SIGNED, -32'sd5, 32'd0);
    do_op(DIV_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(DIV_UNSIGNED, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(2'b10, 32'd100, 32'd7);
    do_op(2'b11, 32'd5, 32'd0);
    do_op(DIV_UNSIGNED, 32'd0, 32'd9);
    do_op(DIV_UNSIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(DIV_UNSIGNED, 32'hFFFF_FFFF, 32'd1);
    do_op(DIV_SIGNED, -32'sd3, 32'd10);
    do_op(DIV_SIGNED, 32'h8000_0000, 32'd1);

    // en while busy is ignored; the next op goes back-to-back at d35.
    do_op(DIV_UNSIGNED, 32'd1000, 32'd3);
    repeat (9) @(negedge clock);
    en = 1'b1; opcode = DIV_SIGNED; dividend = 32'd77; divisor = 32'd5;
    @(negedge clock);
    en = 1'b0;
    do_op(DIV_SIGNED, -32'sd1000, 32'd7);

    // Reset at d20 aborts the op with no valid; a fresh op then completes.
    do_op(DIV_UNSIGNED, 32'd12345, 32'd67);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_op(DIV_SIGNED, -32'sd12345, 32'd67);

    for (int k = 0; k < 1000; k++) begin
      op = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = -32'($urandom_range(0, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
      do_op(op, a, b);
    end

    i = 0;
    while (sb.size() != 0 && i < 100) begin
      @(negedge clock);
      i++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
